fsmc_master: RTL and testbench
==============================

FSMC_MASTER -- requirements
Module: fsmc_master

Interface
REQ-001 Parameter ADDSET, default 4: cycles in ADDR state; legal range 1..255.
REQ-002 Parameter ADDHLD, default 2: cycles in AHOLD state; legal range 1..255.
REQ-003 Parameter DATAST, default 8: cycles in WDATA/RDATA states; legal range 1..255.
REQ-004 Parameter DATAHLD, default 2: cycles in WHOLD/RHOLD states; legal range 1..255.
REQ-005 Parameter BUSTURN, default 2: idle cycles in TURN state after each transaction; legal range 1..255.
REQ-006 clk  input  1  single system clock; all logic on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 req_valid  input  1  host transaction request.
REQ-009 req_ready  output  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high.
REQ-010 req_write  input  1  1 = write, 0 = read; sampled on accept.
REQ-011 req_addr  input  18  bus address; sampled on accept.
REQ-012 req_wdata  input  16  write data; sampled on accept.
REQ-013 rsp_valid  output  1  one-cycle pulse; read data is valid.
REQ-014 rsp_rdata  output  16  captured read data; holds its value until the next capture.
REQ-015 NADV  output  1  address-valid strobe, active-low.
REQ-016 NWE  output  1  write strobe, active-low.
REQ-017 NOE  output  1  read strobe, active-low.
REQ-018 AD  inout  18  multiplexed address/data bus; the block drives it only in the states listed in REQ-021; otherwise it is high-impedance.

Function
REQ-019 States: IDLE, ADDR, AHOLD, WDATA, WHOLD, RDATA, RHOLD, TURN. A single 8-bit down-counter times every state except IDLE.
REQ-020 Strobes and counter by state:
- ADDR: NADV=0.
- WDATA: NWE=0.
- RDATA: NOE=0.
- All other states: every strobe is 1.
- The counter loads N-1 on entry to a state and the state exits when the counter reaches 0, so each state lasts exactly N cycles.
REQ-021 AD drive by state:
- ADDR and AHOLD: latched address.
- WDATA and WHOLD: {2'b00, latched wdata}.
- IDLE, RDATA, RHOLD, TURN: high-impedance.
REQ-022 Transitions:
- IDLE -> ADDR on accept.
- ADDR -> AHOLD.
- AHOLD -> WDATA for a write, RDATA for a read.
- WDATA -> WHOLD.
- RDATA -> RHOLD.
- WHOLD -> TURN; RHOLD -> TURN.
- TURN -> IDLE.
REQ-023 Read capture: on the last RDATA cycle (the cycle before NOE rises), register AD[15:0] into rsp_rdata. Pulse rsp_valid on the first RHOLD cycle. AD[17:16] are ignored.
REQ-024 Write latency: accept to NWE rise = ADDSET+ADDHLD+DATAST cycles. Total write occupancy = ADDSET+ADDHLD+DATAST+DATAHLD+BUSTURN cycles.
REQ-025 Read latency: accept to rsp_valid = ADDSET+ADDHLD+DATAST cycles. Occupancy is the same formula as the write.
REQ-026 Exclusivity: no two strobes are ever low in the same cycle. NADV and NWE/NOE low periods are separated by at least ADDHLD cycles.
REQ-027 Request inputs are ignored outside IDLE. req_valid held high continuously produces back-to-back transactions separated only by TURN.
REQ-028 Latched address/data are immutable for the duration of a transaction, regardless of changes on the req_* inputs.
REQ-029 All strobe outputs and AD output-enable are registered; the block produces no combinational glitches on NADV, NWE, NOE or the AD enable.

Reset
REQ-030 When reset_n=0, regardless of clk:
- State = IDLE, counter = 0.
- NADV=NWE=NOE=1, AD high-impedance.
- req_ready=0, rsp_valid=0, rsp_rdata=16'h0000, latched address/data = 0.
REQ-031 On the first rising clk edge after reset_n deasserts, req_ready becomes 1.
REQ-032 Reset asserted mid-transaction aborts it immediately: strobes return high and AD is released asynchronously. No rsp_valid is produced for an aborted read.

Verification
REQ-033 Write, defaults: request addr 18'h10000, wdata 16'h0F0F.
- Response: NADV low for 4 cycles with AD=18'h10000, then AD held 2 more cycles.
- Then NWE low for 8 cycles with AD=18'h00F0F, data held 2 cycles after NWE rises.
- req_ready returns after 18 cycles total.
REQ-034 Read, defaults: request addr 18'h10000; responder drives AD=18'h02321 while NOE is low.
- Response: AD is high-impedance from the end of AHOLD.
- rsp_valid pulses once, 14 cycles after accept, with rsp_rdata=16'h2321.
REQ-035 Back-to-back: hold req_valid=1 for write 0x00001/0xAAAA then read 0x00002.
- Response: the read's NADV falls exactly BUSTURN+1 = 3 cycles after the write's WHOLD ends.
- No overlapping strobes at any point.
REQ-036 Input stability: change req_addr and req_wdata every cycle during a write.
- Response: AD still shows only the values latched at accept.
REQ-037 Reset abort: assert reset_n=0 in the 3rd RDATA cycle.
- Response: NOE=1 and AD high-impedance within the same cycle; no rsp_valid pulse.
- After release, a fresh write completes normally.
REQ-038 Parameter corner: ADDSET=ADDHLD=DATAST=DATAHLD=BUSTURN=1.
- Response: every state lasts exactly 1 cycle; write occupancy = 5 cycles; read rsp_valid arrives 3 cycles after accept.

Source files
------------

// File: rtl/fsmc_master.sv
// Asynchronous static-memory bus master with a multiplexed address/data bus.
// Each transaction walks a fixed ADDR/AHOLD/DATA/HOLD/TURN timeline from a single down-counter.
module fsmc_master #(
  parameter int ADDSET  = 4,
  parameter int ADDHLD  = 2,
  parameter int DATAST  = 8,
  parameter int DATAHLD = 2,
  parameter int BUSTURN = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [17:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        NADV,
  output logic        NWE,
  output logic        NOE,
  inout  wire  [17:0] AD,
  output logic [2:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready; req_ready is high only in IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    AHOLD = 3'd2,
    WDATA = 3'd3,
    WHOLD = 3'd4,
    RDATA = 3'd5,
    RHOLD = 3'd6,
    TURN  = 3'd7
  } state_t;

  localparam logic [7:0] ADDSET_LD  = 8'(ADDSET - 1);
  localparam logic [7:0] ADDHLD_LD  = 8'(ADDHLD - 1);
  localparam logic [7:0] DATAST_LD  = 8'(DATAST - 1);
  localparam logic [7:0] DATAHLD_LD = 8'(DATAHLD - 1);
  localparam logic [7:0] BUSTURN_LD = 8'(BUSTURN - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        req_ready_q, req_ready_d;
  logic        nadv_q, nadv_d;
  logic        nwe_q, nwe_d;
  logic        noe_q, noe_d;
  logic        ad_oe_q, ad_oe_d;
  logic [17:0] ad_out_q, ad_out_d;
  logic        done;
  logic        unused_ad_hi;

  assign done         = (cnt_q == 8'd0);
  assign unused_ad_hi = ^AD[17:16];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;

    if (state_q != IDLE && !done) cnt_d = cnt_q - 8'd1;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d = ADDR;
          cnt_d   = ADDSET_LD;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
        end
      end
      ADDR: if (done) begin
        state_d = AHOLD;
        cnt_d   = ADDHLD_LD;
      end
      AHOLD: if (done) begin
        state_d = write_q ? WDATA : RDATA;
        cnt_d   = DATAST_LD;
      end
      WDATA: if (done) begin
        state_d = WHOLD;
        cnt_d   = DATAHLD_LD;
      end
      RDATA: if (done) begin
        // Last cycle with NOE low: the external device is still driving the bus.
        state_d     = RHOLD;
        cnt_d       = DATAHLD_LD;
        rdata_d     = AD[15:0];
        rsp_valid_d = 1'b1;
      end
      WHOLD, RHOLD: if (done) begin
        state_d = TURN;
        cnt_d   = BUSTURN_LD;
      end
      TURN: if (done) begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // Pins are decoded from the next state so they switch together with the state register.
    req_ready_d = (state_d == IDLE);
    nadv_d      = (state_d != ADDR);
    nwe_d       = (state_d != WDATA);
    noe_d       = (state_d != RDATA);
    ad_oe_d     = (state_d == ADDR) || (state_d == AHOLD) ||
                  (state_d == WDATA) || (state_d == WHOLD);
    ad_out_d    = ((state_d == ADDR) || (state_d == AHOLD)) ? addr_d : {2'b00, wdata_d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      addr_q      <= 18'd0;
      wdata_q     <= 16'd0;
      write_q     <= 1'b0;
      rdata_q     <= 16'd0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b0;
      nadv_q      <= 1'b1;
      nwe_q       <= 1'b1;
      noe_q       <= 1'b1;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= 18'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      nadv_q      <= nadv_d;
      nwe_q       <= nwe_d;
      noe_q       <= noe_d;
      ad_oe_q     <= ad_oe_d;
      ad_out_q    <= ad_out_d;
    end
  end

  assign AD        = ad_oe_q ? ad_out_q : 18'bz;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign NADV      = nadv_q;
  assign NWE       = nwe_q;
  assign NOE       = noe_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fsmc_master.sv
// Directed bench for fsmc_master: a default-timing instance and an all-ones timing instance
// share the request inputs; a selector picks which one the per-cycle checks observe.
module tb_fsmc_master;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_write;
  logic [17:0] req_addr;
  logic [15:0] req_wdata;
  logic [17:0] resp_val;
  logic        probe_en;
  logic        sel;

  wire         ready0, rsp0, nadv0, nwe0, noe0;
  wire  [15:0] rdata0;
  wire  [17:0] ad0;
  wire  [2:0]  dbg0;
  wire         readyc, rspc, nadvc, nwec, noec;
  wire  [15:0] rdatac;
  wire  [17:0] adc;
  wire  [2:0]  dbgc;

  int n_tests = 0;
  int n_fail  = 0;
  int overlap = 0;
  int p_as, p_ah, p_ds, p_dh, p_bt;

  // Responder drives the bus while NOE is low; the probe drives zero to expose a DUT that fails to release.
  assign ad0 = (!noe0) ? resp_val : (probe_en ? 18'h0 : 18'bz);
  assign adc = (!noec) ? resp_val : (probe_en ? 18'h0 : 18'bz);

  wire        ob_ready = sel ? readyc : ready0;
  wire        ob_rsp   = sel ? rspc   : rsp0;
  wire        ob_nadv  = sel ? nadvc  : nadv0;
  wire        ob_nwe   = sel ? nwec   : nwe0;
  wire        ob_noe   = sel ? noec   : noe0;
  wire [15:0] ob_rdata = sel ? rdatac : rdata0;
  wire [17:0] ob_ad    = sel ? adc    : ad0;
  wire [4:0]  ob_sig   = {ob_ready, ob_rsp, ob_nadv, ob_nwe, ob_noe};

  fsmc_master u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(ready0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp0), .rsp_rdata(rdata0),
    .NADV(nadv0), .NWE(nwe0), .NOE(noe0), .AD(ad0), .dbg_state(dbg0)
  );

  fsmc_master #(.ADDSET(1), .ADDHLD(1), .DATAST(1), .DATAHLD(1), .BUSTURN(1)) u_dut_min (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(readyc), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspc), .rsp_rdata(rdatac),
    .NADV(nadvc), .NWE(nwec), .NOE(noec), .AD(adc), .dbg_state(dbgc)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if ((!nadv0 && !nwe0) || (!nadv0 && !noe0) || (!nwe0 && !noe0)) overlap++;
      if ((!nadvc && !nwec) || (!nadvc && !noec) || (!nwec && !noec)) overlap++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_timing(input logic s);
    sel = s;
    if (s) begin
      p_as = 1; p_ah = 1; p_ds = 1; p_dh = 1; p_bt = 1;
    end else begin
      p_as = 4; p_ah = 2; p_ds = 8; p_dh = 2; p_bt = 2;
    end
  endtask

  // Present a request and return once it has been accepted (#1 after the accepting edge).
  task automatic accept_req(input logic wr, input logic [17:0] a, input logic [15:0] d,
                            input logic hold, output int waits);
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    waits     = 0;
    while (!ob_ready && waits < 100) begin
      @(negedge clk); #1;
      waits++;
    end
    chk("accept_ready", 32'(ob_ready), 32'd1);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  // Runs one transaction and checks every cycle against the timeline model, ending in the IDLE cycle.
  task automatic txn(input string name, input logic wr, input logic [17:0] a, input logic [15:0] d,
                     input logic [17:0] rv, input logic hold, input logic scramble, output int waits);
    int a1, a2, a3, a4, t;
    logic [4:0]  exp_sig;
    logic [17:0] exp_ad;
    a1 = p_as; a2 = a1 + p_ah; a3 = a2 + p_ds; a4 = a3 + p_dh; t = a4 + p_bt;
    resp_val = rv;
    accept_req(wr, a, d, hold, waits);
    for (int c = 1; c <= t + 1; c++) begin
      @(negedge clk);
      exp_sig = {(c == t + 1), (!wr && c == a3 + 1), !(c <= a1),
                 !(wr && c > a2 && c <= a3), !(!wr && c > a2 && c <= a3)};
      if (c <= a2) begin
        probe_en = 1'b0; exp_ad = a;
      end else if (wr && c <= a4) begin
        probe_en = 1'b0; exp_ad = {2'b00, d};
      end else if (!wr && c <= a3) begin
        probe_en = 1'b0; exp_ad = rv;
      end else begin
        probe_en = 1'b1; exp_ad = 18'h0;
      end
      if (scramble && c <= t) begin
        req_addr  = 18'(c * 37) ^ 18'h2AAAA;
        req_wdata = 16'(c * 91) ^ 16'h5555;
      end
      #1;
      chk($sformatf("%s_sig_c%0d", name, c), 32'(ob_sig), 32'(exp_sig));
      chk($sformatf("%s_ad_c%0d", name, c), 32'(ob_ad), 32'(exp_ad));
    end
    if (!wr) chk($sformatf("%s_rdata", name), 32'(ob_rdata), 32'(rv[15:0]));
    probe_en = 1'b0;
  endtask

  initial begin
    int w, w2, pulses;
    reset_n   = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 18'h0;
    req_wdata = 16'h0;
    resp_val  = 18'h0;
    probe_en  = 1'b1;
    set_timing(1'b0);

    // reset state
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_sig0", 32'(ob_sig), 32'b00111);
    chk("rst_rdata0", 32'(rdata0), 32'h0);
    chk("rst_ad0", 32'(ad0), 32'h0);
    chk("rst_state0", 32'(dbg0), 32'd0);
    chk("rst_sigc", 32'({readyc, rspc, nadvc, nwec, noec}), 32'b00111);
    chk("rst_statec", 32'(dbgc), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready_after_edge", 32'(ready0), 32'd1);
    @(negedge clk); #1;
    probe_en = 1'b0;

    txn("wr_def", 1'b1, 18'h10000, 16'h0F0F, 18'h0, 1'b0, 1'b0, w);
    txn("rd_def", 1'b0, 18'h10000, 16'h0, 18'h02321, 1'b0, 1'b0, w);

    // back-to-back with req_valid held high
    txn("b2b_wr", 1'b1, 18'h00001, 16'hAAAA, 18'h0, 1'b1, 1'b0, w);
    txn("b2b_rd", 1'b0, 18'h00002, 16'h0, 18'h3BEEF, 1'b0, 1'b0, w2);
    chk("b2b_gap", 32'(w2), 32'd0);

    txn("wr_scr", 1'b1, 18'h2A5A5, 16'h1234, 18'h0, 1'b0, 1'b1, w);

    // reset abort in the third RDATA cycle
    resp_val = 18'h0ABCD;
    accept_req(1'b0, 18'h00100, 16'h0, 1'b0, w);
    repeat (p_as + p_ah + 3) @(negedge clk);
    #1;
    chk("abort_pre_noe", 32'(noe0), 32'd0);
    reset_n  = 1'b0;
    probe_en = 1'b1;
    #1;
    chk("abort_sig", 32'(ob_sig), 32'b00111);
    chk("abort_ad", 32'(ad0), 32'h0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (i == 2) reset_n = 1'b1;
      if (ob_rsp) pulses++;
    end
    chk("abort_no_rsp", 32'(pulses), 32'd0);
    chk("abort_rdata", 32'(rdata0), 32'h0);
    probe_en = 1'b0;
    txn("wr_post", 1'b1, 18'h3FFFF, 16'hFFFF, 18'h0, 1'b0, 1'b0, w);

    // all-ones timing corner
    set_timing(1'b1);
    txn("wr_min", 1'b1, 18'h12345, 16'hC3C3, 18'h0, 1'b0, 1'b0, w);
    txn("rd_min", 1'b0, 18'h00777, 16'h0, 18'h15A5A, 1'b0, 1'b0, w);

    chk("no_overlap", 32'(overlap), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
